// File: rtl/switch_allocator_pkg.sv
// ---------------------------------------------------------------------------
// switch_allocator_pkg : port indices, select types and index helpers shared
//                        by the 5-port switch allocator.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package switch_allocator_pkg;

  localparam int NUM_PORTS = 5;
  localparam int SEL_W     = NUM_PORTS;

  typedef logic [SEL_W-1:0] sel_t;
  typedef logic [2:0]       port_idx_t;

  localparam port_idx_t PORT_LOCAL = 3'd0;
  localparam port_idx_t PORT_N     = 3'd1;
  localparam port_idx_t PORT_E     = 3'd2;
  localparam port_idx_t PORT_S     = 3'd3;
  localparam port_idx_t PORT_W     = 3'd4;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } alloc_state_e;

  function automatic port_idx_t port_id(input int o);
    case (o)
      0:       return PORT_LOCAL;
      1:       return PORT_N;
      2:       return PORT_E;
      3:       return PORT_S;
      default: return PORT_W;
    endcase
  endfunction

  // Indices 5..7 are not ports and map to an empty select.
  function automatic sel_t port_to_onehot(input port_idx_t idx);
    return (idx <= PORT_W) ? (sel_t'(1) << idx) : '0;
  endfunction

  function automatic port_idx_t onehot_to_port(input sel_t oh);
    port_idx_t result;
    result = PORT_LOCAL;
    for (int i = 0; i < SEL_W; i++) begin
      if (oh[i]) result = port_idx_t'(i);
    end
    return result;
  endfunction

  function automatic port_idx_t next_port(input port_idx_t idx);
    return (idx >= PORT_W) ? PORT_LOCAL : idx + 3'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/switch_allocator_rr_arbiter5.sv
// ---------------------------------------------------------------------------
// rr_arbiter5 : combinational 5-way round-robin pick, searching upward
//               (mod 5) from ptr and returning a one-hot winner.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arbiter5
  import switch_allocator_pkg::*;
(
  input  sel_t      req,
  input  port_idx_t ptr,
  output sel_t      winner
);

  logic [3:0] idx;
  logic       found;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = {1'b0, ptr} + 4'(k);
      if (idx >= 4'(NUM_PORTS)) idx = idx - 4'(NUM_PORTS);
      if (!found && req[idx[2:0]]) begin
        winner = port_to_onehot(idx[2:0]);
        found  = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/switch_allocator.sv
// ---------------------------------------------------------------------------
// switch_allocator : per-output round-robin wormhole allocator for the 5-port
//                    router; optional stall timeout via SWITCH_ALLOC_TIMEOUT_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module switch_allocator
  import switch_allocator_pkg::*;
#(
  parameter int P_NUM_PORTS = 5,
  parameter int P_TIMEOUT   = 255,
  parameter int P_TO_WIDTH  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] req,
  input  logic [2:0] dst_0,
  input  logic [2:0] dst_1,
  input  logic [2:0] dst_2,
  input  logic [2:0] dst_3,
  input  logic [2:0] dst_4,
  input  logic [4:0] tail,
  input  logic [4:0] out_ready,
  output logic [4:0] sel_0,
  output logic [4:0] sel_1,
  output logic [4:0] sel_2,
  output logic [4:0] sel_3,
  output logic [4:0] sel_4,
  output logic [4:0] lock,
  output logic [4:0] grant,
  output logic [4:0] timeout_err
);

  if (P_NUM_PORTS != NUM_PORTS) begin : g_bad_ports
    $error("switch_allocator supports exactly 5 ports");
  end
  if (P_TIMEOUT < 1 || P_TIMEOUT >= (1 << P_TO_WIDTH)) begin : g_bad_timeout
    $error("P_TIMEOUT must lie in 1 .. 2**P_TO_WIDTH-1");
  end

  port_idx_t            dst   [NUM_PORTS];
  sel_t                 sel_r [NUM_PORTS];
  sel_t                 owned;
  logic [NUM_PORTS-1:0] xfer;

  assign dst[0] = dst_0;
  assign dst[1] = dst_1;
  assign dst[2] = dst_2;
  assign dst[3] = dst_3;
  assign dst[4] = dst_4;

  assign sel_0 = sel_r[0];
  assign sel_1 = sel_r[1];
  assign sel_2 = sel_r[2];
  assign sel_3 = sel_r[3];
  assign sel_4 = sel_r[4];

  // An input holding any output is barred from requesting elsewhere.
  always_comb begin
    owned = '0;
    for (int o = 0; o < NUM_PORTS; o++) owned = owned | sel_r[o];
  end

  always_comb begin
    grant = '0;
    for (int o = 0; o < NUM_PORTS; o++) grant = grant | (sel_r[o] & {NUM_PORTS{xfer[o]}});
  end

  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
    sel_t         dmatch;
    sel_t         cand;
    sel_t         win;
    sel_t         sel_q;
    port_idx_t    ptr_q;
    port_idx_t    arb_ptr;
    port_idx_t    owner_next;
    alloc_state_e state_q;
    logic         lock_q;
    logic         tail_xfer;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_in
      assign dmatch[i] = (dst[i] == port_id(o));
    end

    assign cand       = req & dmatch & ~owned;
    assign xfer[o]    = (state_q == ST_LOCKED) && out_ready[o] && (|(sel_q & req & dmatch));
    assign tail_xfer  = xfer[o] && (|(sel_q & tail));
    assign owner_next = next_port(onehot_to_port(sel_q));
    // A tail transfer re-arbitrates in the same cycle from the advanced pointer.
    assign arb_ptr    = tail_xfer ? owner_next : ptr_q;

    rr_arbiter5 u_arb (
      .req    (cand),
      .ptr    (arb_ptr),
      .winner (win)
    );

    assign sel_r[o] = sel_q;
    assign lock[o]  = lock_q;

`ifdef SWITCH_ALLOC_TIMEOUT_EN
    localparam logic [P_TO_WIDTH-1:0] STALL_LAST = P_TO_WIDTH'(P_TIMEOUT - 1);
    logic [P_TO_WIDTH-1:0] stall_q;
    logic                  terr_q;
    assign timeout_err[o] = terr_q;
`else
    assign timeout_err[o] = 1'b0;
`endif

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= ST_IDLE;
        sel_q   <= '0;
        lock_q  <= 1'b0;
        ptr_q   <= PORT_LOCAL;
`ifdef SWITCH_ALLOC_TIMEOUT_EN
        stall_q <= '0;
        terr_q  <= 1'b0;
`endif
      end else begin
`ifdef SWITCH_ALLOC_TIMEOUT_EN
        terr_q <= 1'b0;
`endif
        case (state_q)
          ST_IDLE: begin
`ifdef SWITCH_ALLOC_TIMEOUT_EN
            stall_q <= '0;
`endif
            if (|win) begin
              state_q <= ST_LOCKED;
              sel_q   <= win;
              lock_q  <= 1'b1;
            end
          end
          ST_LOCKED: begin
            if (xfer[o]) begin
`ifdef SWITCH_ALLOC_TIMEOUT_EN
              stall_q <= '0;
`endif
              if (tail_xfer) begin
                ptr_q  <= owner_next;
                sel_q  <= win;
                lock_q <= |win;
                if (!(|win)) state_q <= ST_IDLE;
              end
            end
`ifdef SWITCH_ALLOC_TIMEOUT_EN
            else if (stall_q == STALL_LAST) begin
              state_q <= ST_IDLE;
              sel_q   <= '0;
              lock_q  <= 1'b0;
              ptr_q   <= owner_next;
              stall_q <= '0;
              terr_q  <= 1'b1;
            end else begin
              stall_q <= stall_q + P_TO_WIDTH'(1);
            end
`endif
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_switch_allocator.sv
// ---------------------------------------------------------------------------
// tb_switch_allocator : directed stimulus for switch_allocator, checked each
//                       cycle against a packet-level ownership model.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_switch_allocator;

`ifdef SWITCH_ALLOC_TIMEOUT_EN
  localparam int TO_EN    = 1;
  localparam int TIMEOUT  = 8;
  localparam int BP_STALL = 6;
`else
  localparam int TO_EN    = 0;
  localparam int TIMEOUT  = 255;
  localparam int BP_STALL = 10;
  localparam int HOLD_CYC = 12;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] req = '0;
  logic [4:0] tail = '0;
  logic [4:0] out_ready = 5'b11111;
  logic [2:0] dstv [5];
  logic [4:0] selv [5];
  logic [4:0] lock, grant, timeout_err;

  switch_allocator #(
    .P_NUM_PORTS (5),
    .P_TIMEOUT   (TIMEOUT),
    .P_TO_WIDTH  (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .dst_0       (dstv[0]),
    .dst_1       (dstv[1]),
    .dst_2       (dstv[2]),
    .dst_3       (dstv[3]),
    .dst_4       (dstv[4]),
    .tail        (tail),
    .out_ready   (out_ready),
    .sel_0       (selv[0]),
    .sel_1       (selv[1]),
    .sel_2       (selv[2]),
    .sel_3       (selv[3]),
    .sel_4       (selv[4]),
    .lock        (lock),
    .grant       (grant),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Per-input flit queues, each flit encoded as dst*2 + tail.
  int fq [5][$];
  bit hold [5] = '{default: 1'b0};
  logic [4:0] gs;
  logic       rs;

  task automatic push_pkt(input int i, input int d, input int len);
    for (int f = 0; f < len; f++) fq[i].push_back(d * 2 + ((f == len - 1) ? 1 : 0));
  endtask

  task automatic apply_inputs();
    for (int i = 0; i < 5; i++) begin
      if (fq[i].size() > 0) begin
        dstv[i] = 3'(fq[i][0] / 2);
        tail[i] = (fq[i][0] % 2) == 1;
      end else begin
        tail[i] = 1'b0;
      end
      req[i] = (fq[i].size() > 0) && !hold[i];
    end
  endtask

  task automatic tick();
    @(negedge clk);
    gs = grant;
    rs = rst;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      if (gs[i] && !rs) void'(fq[i].pop_front());
    end
    apply_inputs();
    #1;
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < 5; i++) if (fq[i].size() > 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drain(input string name, input int max);
    int n = 0;
    while (!(all_empty() && lock == 5'b0) && n < max) begin
      tick();
      n++;
    end
    chk(name, {31'b0, all_empty() && lock == 5'b0}, 32'd1);
  endtask

  // Reference model: owner input per output (-1 = free), pointer, stall count.
  int m_own   [5] = '{default: -1};
  int m_ptr   [5] = '{default: 0};
  int m_stall [5] = '{default: 0};
  bit m_terr  [5] = '{default: 1'b0};

  function automatic int pick(input int o, input int start, input logic [4:0] owned);
    for (int k = 0; k < 5; k++) begin
      int i;
      i = (start + k) % 5;
      if (req[i] && dstv[i] == 3'(o) && !owned[i]) return i;
    end
    return -1;
  endfunction

  always @(negedge clk) begin : compare
    int         n_own [5];
    int         n_ptr [5];
    int         n_stall [5];
    bit         n_terr [5];
    bit         xf [5];
    logic [4:0] e_grant, e_lock, e_terr, owned;
    int         w;
    e_grant = '0;
    e_lock  = '0;
    e_terr  = '0;
    owned   = '0;
    for (int o = 0; o < 5; o++) begin
      xf[o] = 1'b0;
      e_terr[o] = m_terr[o];
      if (m_own[o] >= 0) begin
        w = m_own[o];
        owned[w] = 1'b1;
        e_lock[o] = 1'b1;
        xf[o] = req[w] && dstv[w] == 3'(o) && out_ready[o];
        if (xf[o]) e_grant[w] = 1'b1;
        if (!rst) assert (!(req[w] && dstv[w] != 3'(o)))
          else $error("dst of owner %0d changed while output %0d locked", w, o);
      end
    end
    for (int o = 0; o < 5; o++)
      chk($sformatf("sel_%0d", o), selv[o], (m_own[o] >= 0) ? 32'(1 << m_own[o]) : 32'd0);
    chk("lock", lock, e_lock);
    chk("grant", grant, e_grant);
    chk("timeout_err", timeout_err, e_terr);

    for (int o = 0; o < 5; o++) begin
      n_own[o]   = m_own[o];
      n_ptr[o]   = m_ptr[o];
      n_stall[o] = m_stall[o];
      n_terr[o]  = 1'b0;
      w = m_own[o];
      if (rst) begin
        n_own[o] = -1;
        n_ptr[o] = 0;
        n_stall[o] = 0;
      end else if (w < 0) begin
        n_own[o] = pick(o, m_ptr[o], owned);
      end else if (xf[o]) begin
        n_stall[o] = 0;
        if (tail[w]) begin
          n_ptr[o] = (w + 1) % 5;
          n_own[o] = pick(o, n_ptr[o], owned);
        end
      end else begin
        n_stall[o] = m_stall[o] + 1;
        if (TO_EN == 1 && n_stall[o] == TIMEOUT) begin
          n_own[o]   = -1;
          n_ptr[o]   = (w + 1) % 5;
          n_stall[o] = 0;
          n_terr[o]  = 1'b1;
        end
      end
    end
    for (int o = 0; o < 5; o++) begin
      m_own[o]   = n_own[o];
      m_ptr[o]   = n_ptr[o];
      m_stall[o] = n_stall[o];
      m_terr[o]  = n_terr[o];
    end
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got timeout, expected end of stimulus");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         ngrant, nlock;
    logic [4:0] last;
    logic [4:0] seq [$];
    for (int i = 0; i < 5; i++) dstv[i] = 3'd0;

    repeat (3) tick();
    chk("rst_sel0", selv[0], 0);
    chk("rst_lock", lock, 0);
    chk("rst_grant", grant, 0);
    chk("rst_terr", timeout_err, 0);
    rst = 1'b0;

    // Invalid destination never requests.
    fq[0].push_back(6 * 2 + 1);
    apply_inputs();
    repeat (3) tick();
    chk("bad_dst_lock", lock, 0);
    fq[0].delete();
    apply_inputs();
    tick();

    // Single-flit packet 2 -> 3.
    push_pkt(2, 3, 1);
    apply_inputs();
    #1;
    chk("t1_arb_grant", grant, 0);
    tick();
    chk("t1_sel3", selv[3], 5'b00100);
    chk("t1_grant", grant, 5'b00100);
    tick();
    chk("t1_sel3_idle", selv[3], 0);
    chk("t1_lock", lock, 0);
    chk("t1_ptr3", m_ptr[3], 3);

    // Contention: inputs 0,1,4 send 3-flit packets to output 1.
    push_pkt(0, 1, 3);
    push_pkt(1, 1, 3);
    push_pkt(4, 1, 3);
    apply_inputs();
    ngrant = 0;
    nlock  = 0;
    last   = '0;
    for (int c = 0; c < 12; c++) begin
      tick();
      ngrant += $countones(grant & 5'b10011);
      if (lock[1]) nlock++;
      if (selv[1] != 0 && selv[1] != last) seq.push_back(selv[1]);
      last = selv[1];
    end
    chk("t2_grants", ngrant, 9);
    chk("t2_lock_cycles", nlock, 9);
    chk("t2_owner_count", seq.size(), 3);
    if (seq.size() == 3) begin
      chk("t2_owner0", seq[0], 5'b00001);
      chk("t2_owner1", seq[1], 5'b00010);
      chk("t2_owner2", seq[2], 5'b10000);
    end
    chk("t2_ptr1", m_ptr[1], 0);

    // Backpressure on output 0 mid-packet.
    push_pkt(3, 0, 4);
    apply_inputs();
    tick();
    chk("t3_first", grant, 5'b01000);
    tick();
    out_ready[0] = 1'b0;
    #1;
    for (int k = 0; k < BP_STALL; k++) begin
      chk("t3_hold_sel", selv[0], 5'b01000);
      chk("t3_hold_grant", grant, 0);
      tick();
    end
    out_ready[0] = 1'b1;
    #1;
    chk("t3_resume", grant, 5'b01000);
    drain("t3_drain", 20);

    // Five disjoint paths at once.
    push_pkt(0, 4, 2);
    push_pkt(1, 0, 2);
    push_pkt(2, 1, 2);
    push_pkt(3, 2, 2);
    push_pkt(4, 3, 2);
    apply_inputs();
    tick();
    chk("t4_sel4", selv[4], 5'b00001);
    chk("t4_sel0", selv[0], 5'b00010);
    chk("t4_sel1", selv[1], 5'b00100);
    chk("t4_sel2", selv[2], 5'b01000);
    chk("t4_sel3", selv[3], 5'b10000);
    chk("t4_grant_a", grant, 5'b11111);
    tick();
    chk("t4_grant_b", grant, 5'b11111);
    drain("t4_drain", 10);

    // Reset during the second flit of a 4-flit packet 4 -> 2.
    push_pkt(4, 2, 4);
    apply_inputs();
    tick();
    chk("t5_own", selv[2], 5'b10000);
    tick();
    push_pkt(0, 2, 1);
    rst = 1'b1;
    apply_inputs();
    #1;
    chk("t5_mid_grant", grant, 5'b10000);
    tick();
    chk("t5_rst_sel2", selv[2], 0);
    chk("t5_rst_lock", lock, 0);
    chk("t5_rst_grant", grant, 0);
    rst = 1'b0;
    tick();
    chk("t5_rearb", selv[2], 5'b00001);
    chk("t5_rearb_grant", grant, 5'b00001);
    tick();
    chk("t5_next", selv[2], 5'b10000);
    drain("t5_drain", 12);

    // Owner 2 of output 4 drops req mid-packet while input 3 waits.
    push_pkt(2, 4, 3);
    apply_inputs();
    tick();
    chk("t6_own", selv[4], 5'b00100);
    tick();
    hold[2] = 1'b1;
    push_pkt(3, 4, 1);
    apply_inputs();
    #1;
`ifdef SWITCH_ALLOC_TIMEOUT_EN
    for (int k = 0; k < TIMEOUT; k++) begin
      chk("t6_stall_sel", selv[4], 5'b00100);
      chk("t6_stall_terr", timeout_err, 0);
      tick();
    end
    chk("t6_release_sel", selv[4], 0);
    chk("t6_terr_pulse", timeout_err, 5'b10000);
    tick();
    chk("t6_next_owner", selv[4], 5'b01000);
    chk("t6_terr_clear", timeout_err, 0);
    hold[2] = 1'b0;
    apply_inputs();
`else
    for (int k = 0; k < HOLD_CYC; k++) begin
      chk("t6_hold_sel", selv[4], 5'b00100);
      chk("t6_hold_grant", grant, 0);
      chk("t6_hold_terr", timeout_err, 0);
      tick();
    end
    hold[2] = 1'b0;
    apply_inputs();
    #1;
    chk("t6_resume", grant, 5'b00100);
`endif
    drain("t6_drain", 20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/switch_allocator.md
Name: switch_allocator

Overview:
- Per-output-port switch allocator for the 5-port router. Produces the one-hot crossbar selects `sel_0..sel_4` that the data switch consumes.
- Arbitrates input-port head flits round-robin per output and holds each output locked to its winner until the tail flit transfers (wormhole).
- Drives per-input grant pulses back to the input buffers.

Parameters:
- P_NUM_PORTS, 5, number of router ports; only 5 is supported and it fixes all 5-bit vectors.
- P_TIMEOUT, 255, stall cycles before a forced release (used only with the optional feature).
- P_TO_WIDTH, 8, width of the per-output stall counter; P_TIMEOUT must be < 2^P_TO_WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset is synchronous and active-high
- req  input  5  bit i: input i presents a valid flit
- dst_0..dst_4  input  3 each  destination output of input i's flit; values 5..7 are invalid
- tail  input  5  bit i: input i's flit is a packet tail; a head+tail flit is a single-flit packet
- out_ready  input  5  bit o: output o can accept a flit this cycle (downstream credit available)
- sel_0..sel_4  output  5 each  registered one-hot owner of output o; 0 means none (switch drives 0)
- lock  output  5  registered; bit o is set while output o is owned
- grant  output  5  combinational; bit i: input i's flit moves through the switch this cycle
- timeout_err  output  5  one-cycle pulse per output on forced release (feature only, else tied 0)

Behaviour:
- Reset: all `sel_o`=0, `lock`=0, round-robin pointers `ptr_o`=0, stall counters 0, `timeout_err`=0.
  - Reset has priority over all other events; asserting it mid-packet drops ownership immediately.
- Eligibility: input i requests output o when `req[i]`, `dst_i`==o, and input i does not own another output.
  - Invalid `dst_i` (5..7) never requests anything.
- Per-output state machine, two states:
  - IDLE, with `sel_o`=0: each cycle, search requesters starting at `ptr_o`, ascending mod 5.
    - On a winner w: next `sel_o` = 1<<w, state becomes LOCKED.
    - No grant is issued in the arbitration cycle. The first transfer happens one cycle later at the earliest (latency 1).
  - LOCKED, owner w:
    - Transfer = `req[w]` && `dst_w`==o && `out_ready[o]`; `grant[w]` = transfer.
    - Transfer with `tail[w]`: `ptr_o` becomes (w+1) mod 5.
    - In that same cycle, rearbitrate among requesters excluding w, searching from the new `ptr_o`.
    - If there is a winner: `sel_o` becomes the new one-hot value, giving back-to-back packets. Otherwise: `sel_o`=0, state IDLE.
    - No transfer: hold `sel_o`.
- Invariants:
  - At most one bit set per `sel_o`.
  - No input set in two `sel_o`.
  - `grant[i]` implies the owning `sel_o` has bit i set.
  - `lock[o]` == |`sel_o`.
- Simultaneous heads from all 5 inputs to one output: served in pointer order, one packet each, with no starvation; worst-case wait is 4 packets.
- A held owner whose `req` drops mid-packet keeps the lock; no transfer occurs and no grant is issued.
- `dst_w` changing while locked is a protocol violation. No transfer occurs; the bench flags it via an assertion.

Optional Feature:
- Macro `SWITCH_ALLOC_TIMEOUT_EN`.
- When defined:
  - Each LOCKED output counts consecutive cycles without a transfer; the counter clears on any transfer or on IDLE.
  - On reaching P_TIMEOUT: `sel_o` becomes 0, state IDLE, `ptr_o` becomes (w+1) mod 5, and `timeout_err[o]` pulses for 1 cycle.
- When undefined: no counters, `timeout_err` is tied 0, and the lock is held indefinitely.

Decomposition:
- Shared package holds:
  - port-index constants (0..4: local, N, E, S, W) and the port count 5;
  - the one-hot select width and a helper function that converts a port index to one-hot.
- One sub-module, `rr_arbiter5`: 5-bit request, 3-bit pointer, 5-bit one-hot winner, combinational.
  - Instantiated once per output with a generate loop.

Test Plan:
- Single-flit packet: input 2 → output 3, head+tail, `out_ready`=1.
  - Cycle 1: `sel_3`=00100.
  - Cycle 1: `grant`[2]=1.
  - Cycle 2: `sel_3`=0 and `ptr_3`=3.
- Contention: inputs 0, 1, 4 each send a 3-flit packet to output 1.
  - Owners in order 0, 1, 4; back-to-back with no idle cycle.
  - 9 grants total; flits are never interleaved.
- Backpressure: `out_ready`[0]=0 for 10 cycles mid-packet.
  - `sel_0` stays fixed and `grant` stays 0.
  - Transfer resumes the cycle `out_ready` returns high.
- Parallel paths: 0→4, 1→0, 2→1, 3→2, 4→3 simultaneously.
  - All five `sel` vectors are distinct one-hot; all five grants fire per cycle.
- Reset mid-packet: assert `rst` during the 2nd flit of a 4-flit packet.
  - The next cycle shows all `sel`=0, `lock`=0 and `grant`=0.
  - The packet rearbitrates from `ptr`=0.
- With `SWITCH_ALLOC_TIMEOUT_EN` and P_TIMEOUT=8: owner's `req` stays low.
  - After 8 stall cycles: `timeout_err` pulses for 1 cycle and the output is released to the next requester.
